// File: rtl/noc_switch_input_port_pkg.sv
// Shared flit layout and routing constants for the NoC switch input port.
package noc_switch_input_port_pkg;

    // Head and tail flags sit at the top of the flit, counted down from the MSB.
    localparam int HEAD_OFS    = 1;
    localparam int TAIL_OFS    = 2;
    localparam int PATH_WD     = 7;
    localparam int ROUTE_SHIFT = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with occupancy count; pointers wrap at DEPTH.
module noc_flit_fifo #(
    parameter int WIDTH     = 80,
    parameter int DEPTH     = 6,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wptr;
    logic [LOG_DEPTH-1:0] rptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    function automatic logic [LOG_DEPTH-1:0] wrap_inc(input logic [LOG_DEPTH-1:0] p);
        return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wrap_inc(wptr);
            if (do_pop)  rptr <= wrap_inc(rptr);
            count <= count + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/noc_switch_input_port.sv
// Switch input port: buffers link flits, decodes source route, requests
// one crossbar output per packet and forwards flits on grant.
module noc_switch_input_port
    import noc_switch_input_port_pkg::*;
#(
    parameter int FLIT_WIDTH       = 80,
    parameter int BUFFER_DEPTH     = 6,
    parameter int LOG_BUFFER_DEPTH = 3,
    parameter int NUM_OUTPUTS      = 4,
    parameter int LOG_OUTPUTS      = 2,
    parameter int PATH_WD          = noc_switch_input_port_pkg::PATH_WD,
    parameter int STALL_SLACK      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  FLIT_in,
    input  logic                   VALID_in,
    output logic                   BWDAUX1_out,
    output logic [FLIT_WIDTH-1:0]  flit_out,
    output logic [NUM_OUTPUTS-1:0] req_out,
    input  logic                   grant_in,
    output logic                   valid_out,
    output logic                   overflow_err,
    output logic                   protocol_err
);

    logic [FLIT_WIDTH-1:0]       front;
    logic [LOG_BUFFER_DEPTH:0]   count;
    logic [LOG_BUFFER_DEPTH:0]   count_next;
    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    logic                        head;
    logic                        tail;
    logic                        port_bad;
    logic                        discard;
    logic                        first_q;
    logic [LOG_OUTPUTS-1:0]      port_q;
    state_t                      state;
    state_t                      state_next;

    noc_flit_fifo #(
        .WIDTH     (FLIT_WIDTH),
        .DEPTH     (BUFFER_DEPTH),
        .LOG_DEPTH (LOG_BUFFER_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (FLIT_in),
        .pop   (pop),
        .rdata (front),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head     = front[FLIT_WIDTH-HEAD_OFS];
    assign tail     = front[FLIT_WIDTH-TAIL_OFS];
    assign port_bad = {1'b0, front[LOG_OUTPUTS-1:0]} >= (LOG_OUTPUTS+1)'(NUM_OUTPUTS);

    // In IDLE anything at the front that cannot open a packet is dropped.
    assign discard   = (state == IDLE) & ~empty & (~head | port_bad);
    assign valid_out = (state == ACTIVE) & ~empty;
    assign pop       = (valid_out & grant_in) | discard;
    assign push      = VALID_in & (~full | pop);

    assign count_next = count + (LOG_BUFFER_DEPTH+1)'(push)
                              - (LOG_BUFFER_DEPTH+1)'(pop);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (~empty & head & ~port_bad) state_next = ACTIVE;
            ACTIVE: if (valid_out & grant_in & tail) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            port_q       <= '0;
            first_q      <= 1'b0;
            BWDAUX1_out  <= 1'b0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                port_q  <= front[LOG_OUTPUTS-1:0];
                first_q <= 1'b1;
            end else if (pop) begin
                first_q <= 1'b0;
            end
            BWDAUX1_out <= count_next >=
                (LOG_BUFFER_DEPTH+1)'(BUFFER_DEPTH - STALL_SLACK);
            if (VALID_in & ~push) overflow_err <= 1'b1;
            if (discard)          protocol_err <= 1'b1;
        end
    end

    always_comb begin
        req_out = '0;
        if (state == ACTIVE) req_out[port_q] = 1'b1;
    end

    // Only the packet-opening head gets its route advanced; a stray head
    // inside a packet is passed through like body data.
    always_comb begin
        flit_out = front;
        if (head & first_q)
            flit_out[PATH_WD-1:0] = front[PATH_WD-1:0] >> LOG_OUTPUTS;
    end

endmodule

// File: tb/tb_noc_switch_input_port.sv
// Directed bench for the NoC switch input port.
module tb_noc_switch_input_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] FLIT_in;
    logic        VALID_in;
    logic        BWDAUX1_out;
    logic [79:0] flit_out;
    logic [3:0]  req_out;
    logic        grant_in;
    logic        valid_out;
    logic        overflow_err;
    logic        protocol_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    noc_switch_input_port dut (
        .clk          (clk),
        .rst          (rst),
        .FLIT_in      (FLIT_in),
        .VALID_in     (VALID_in),
        .BWDAUX1_out  (BWDAUX1_out),
        .flit_out     (flit_out),
        .req_out      (req_out),
        .grant_in     (grant_in),
        .valid_out    (valid_out),
        .overflow_err (overflow_err),
        .protocol_err (protocol_err)
    );

    function automatic logic [79:0] mk(input logic h, input logic t,
                                       input logic [70:0] pl,
                                       input logic [6:0] rt);
        return {h, t, pl, rt};
    endfunction

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1;
        VALID_in = 1'b0;
        FLIT_in = '0;
        grant_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", req_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_stall", BWDAUX1_out, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_count", dut.u_fifo.count, 0);
        rst = 1'b0;

        // 3-flit packet to port 2
        FLIT_in = mk(1, 0, 71'h11, 7'b0000110);
        VALID_in = 1'b1;
        grant_in = 1'b1;
        @(negedge clk);
        check("t1_req_idle", req_out, 0);
        FLIT_in = mk(0, 0, 71'h12, 7'h55);
        @(negedge clk);
        check("t1_req_h", req_out, 4'b0100);
        check("t1_valid", valid_out, 1);
        check("t1_head", flit_out, mk(1, 0, 71'h11, 7'b0000001));
        FLIT_in = mk(0, 1, 71'h13, 7'h2a);
        @(negedge clk);
        VALID_in = 1'b0;
        check("t1_req_b", req_out, 4'b0100);
        check("t1_body", flit_out, mk(0, 0, 71'h12, 7'h55));
        @(negedge clk);
        check("t1_req_t", req_out, 4'b0100);
        check("t1_tail", flit_out, mk(0, 1, 71'h13, 7'h2a));
        @(negedge clk);
        check("t1_req_end", req_out, 0);
        check("t1_valid_end", valid_out, 0);

        // single-flit packet to port 3
        FLIT_in = mk(1, 1, 71'h21, 7'b0000011);
        VALID_in = 1'b1;
        @(negedge clk);
        VALID_in = 1'b0;
        check("t2_req_w", req_out, 0);
        check("t2_valid_w", valid_out, 0);
        @(negedge clk);
        check("t2_req", req_out, 4'b1000);
        check("t2_valid", valid_out, 1);
        check("t2_flit", flit_out, mk(1, 1, 71'h21, 7'b0000000));
        @(negedge clk);
        check("t2_req_end", req_out, 0);
        check("t2_count", dut.u_fifo.count, 0);

        // body flit while idle
        grant_in = 1'b0;
        FLIT_in = mk(0, 0, 71'h31, 7'h10);
        VALID_in = 1'b1;
        @(negedge clk);
        VALID_in = 1'b0;
        check("t3_perr_pre", protocol_err, 0);
        @(negedge clk);
        check("t3_perr", protocol_err, 1);
        check("t3_req", req_out, 0);
        check("t3_count", dut.u_fifo.count, 0);

        // fill with grant low: head to port 1 + 5 bodies, 7th dropped
        for (int i = 0; i < 7; i++) begin
            FLIT_in = (i == 0) ? mk(1, 0, 71'd100, 7'b0000001)
                               : mk(0, (i == 6), 71'(100 + i), 7'h0);
            VALID_in = 1'b1;
            @(negedge clk);
            if (i == 2) check("t4_stall_3", BWDAUX1_out, 0);
            if (i == 3) check("t4_stall_4", BWDAUX1_out, 1);
            if (i == 5) begin
                check("t4_count_6", dut.u_fifo.count, 6);
                check("t4_ovf_pre", overflow_err, 0);
            end
        end
        VALID_in = 1'b0;
        check("t4_ovf", overflow_err, 1);
        check("t4_count_7", dut.u_fifo.count, 6);
        check("t4_stall_full", BWDAUX1_out, 1);

        // full: push and pop together, order kept across wrap
        FLIT_in = mk(0, 1, 71'd200, 7'h0);
        VALID_in = 1'b1;
        grant_in = 1'b1;
        @(negedge clk);
        VALID_in = 1'b0;
        check("t5_count", dut.u_fifo.count, 6);
        check("t5_req", req_out, 4'b0010);
        check("t5_f101", flit_out, mk(0, 0, 71'd101, 7'h0));
        for (int k = 102; k <= 105; k++) begin
            @(negedge clk);
            check("t5_order", flit_out, mk(0, 0, 71'(k), 7'h0));
        end
        @(negedge clk);
        check("t5_last", flit_out, mk(0, 1, 71'd200, 7'h0));
        @(negedge clk);
        check("t5_req_end", req_out, 0);
        check("t5_empty", dut.u_fifo.count, 0);

        // reset mid-packet
        grant_in = 1'b0;
        FLIT_in = mk(1, 0, 71'd300, 7'b0000010);
        VALID_in = 1'b1;
        @(negedge clk);
        FLIT_in = mk(0, 0, 71'd301, 7'h0);
        @(negedge clk);
        VALID_in = 1'b0;
        check("t6_req_pre", req_out, 4'b0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_req", req_out, 0);
        check("t6_valid", valid_out, 0);
        check("t6_stall", BWDAUX1_out, 0);
        check("t6_count", dut.u_fifo.count, 0);
        check("t6_ovf", overflow_err, 0);
        check("t6_perr", protocol_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
